// File: rtl/exmem_bram_arbiter.sv
// Two-port arbiter/sequencer for the single-port user BRAM with programmable exmem wait states.
// Optional performance counters are enabled by defining EXMEM_BRAM_ARB_PERF_EN.
module exmem_bram_arbiter #(
  parameter int DELAYS = 10,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        we0,
  input  logic [3:0]        we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic [1:0]        owner,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_a,
  output logic [31:0]       bram_di,
  input  logic [31:0]       bram_do,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
);

  localparam int DW = (DELAYS > 1) ? $clog2(DELAYS) : 1;
  localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'((DELAYS > 0) ? DELAYS - 1 : 0);
  localparam logic [RW-1:0] RD_LAST  = RW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DLY    = 3'd1,
    ISSUE  = 3'd2,
    RDWAIT = 3'd3,
    ACK    = 3'd4
  } state_t;

  function automatic logic [1:0] onehot(input logic id);
    onehot = id ? 2'b10 : 2'b01;
  endfunction

  state_t            state_r, state_nxt_s;
  logic              win_r, win_nxt_s, win_sel_s, last_gnt_r;
  logic [3:0]        we_r, we_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;
  logic [DW-1:0]     dly_cnt_r;
  logic [RW-1:0]     rd_cnt_r;
  logic              cap_s, issue_s, win_req_s;

  logic              ack0_r, ack1_r, bram_en_r;
  logic [1:0]        owner_r;
  logic [3:0]        bram_we_r;
  logic [ADDR_W-1:0] bram_a_r;
  logic [31:0]       bram_di_r, rdata_r;

  // Next-state, winner selection and attribute latch values
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_r;
    we_nxt_s    = we_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    cap_s       = 1'b0;
    // Round-robin on a tie: the port that was not served last wins.
    win_sel_s   = (req0 && req1) ? ~last_gnt_r : req1;
    win_req_s   = win_r ? req1 : req0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          win_nxt_s   = win_sel_s;
          we_nxt_s    = win_sel_s ? we1 : we0;
          addr_nxt_s  = win_sel_s ? addr1 : addr0;
          wdata_nxt_s = win_sel_s ? wdata1 : wdata0;
          state_nxt_s = (DELAYS > 0) ? DLY : ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DLY: begin
        if (!win_req_s) begin
          state_nxt_s = IDLE;
        end else if (dly_cnt_r == DLY_LAST) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = DLY;
        end
      end
      ISSUE: begin
        state_nxt_s = (we_r != 4'h0) ? ACK : RDWAIT;
      end
      RDWAIT: begin
        if (rd_cnt_r == RD_LAST) begin
          cap_s       = 1'b1;
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = RDWAIT;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    issue_s = (state_nxt_s == ISSUE);
  end

  // State, latched attributes, wait counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      win_r      <= 1'b0;
      last_gnt_r <= 1'b1;
      we_r       <= 4'h0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      dly_cnt_r  <= {DW{1'b0}};
      rd_cnt_r   <= {RW{1'b0}};
      owner_r    <= 2'b00;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      bram_en_r  <= 1'b0;
      bram_we_r  <= 4'h0;
      bram_a_r   <= {ADDR_W{1'b0}};
      bram_di_r  <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      win_r      <= win_nxt_s;
      last_gnt_r <= (state_r == ACK) ? win_r : last_gnt_r;
      we_r       <= we_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      dly_cnt_r  <= (state_r == DLY) ? dly_cnt_r + DW'(1) : {DW{1'b0}};
      rd_cnt_r   <= (state_r == RDWAIT) ? rd_cnt_r + RW'(1) : {RW{1'b0}};
      owner_r    <= (state_nxt_s != IDLE) ? onehot(win_nxt_s) : 2'b00;
      ack0_r     <= (state_nxt_s == ACK) && !win_nxt_s;
      ack1_r     <= (state_nxt_s == ACK) && win_nxt_s;
      bram_en_r  <= issue_s;
      bram_we_r  <= issue_s ? we_nxt_s : 4'h0;
      bram_a_r   <= issue_s ? addr_nxt_s : {ADDR_W{1'b0}};
      bram_di_r  <= (issue_s && (we_nxt_s != 4'h0)) ? wdata_nxt_s : 32'h0000_0000;
      rdata_r    <= cap_s ? bram_do : rdata_r;
    end
  end

  assign ack0    = ack0_r;
  assign ack1    = ack1_r;
  assign owner   = owner_r;
  assign bram_en = bram_en_r;
  assign bram_we = bram_we_r;
  assign bram_a  = bram_a_r;
  assign bram_di = bram_di_r;
  assign rdata   = rdata_r;

`ifdef EXMEM_BRAM_ARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'h0001;
  endfunction

  logic [15:0] grant0_r, grant1_r, conflict_r;

  // Saturating grant and conflict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_r   <= 16'h0000;
      grant1_r   <= 16'h0000;
      conflict_r <= 16'h0000;
    end else begin
      grant0_r   <= (state_r == ACK && !win_r) ? sat_inc(grant0_r) : grant0_r;
      grant1_r   <= (state_r == ACK && win_r) ? sat_inc(grant1_r) : grant1_r;
      conflict_r <= (state_r == IDLE && req0 && req1) ? sat_inc(conflict_r) : conflict_r;
    end
  end

  assign grant_cnt0   = grant0_r;
  assign grant_cnt1   = grant1_r;
  assign conflict_cnt = conflict_r;
`else
  assign grant_cnt0   = 16'h0000;
  assign grant_cnt1   = 16'h0000;
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_exmem_bram_arbiter.sv
// Self-checking bench for exmem_bram_arbiter: table-driven single transactions, scoreboarded
// BRAM issue/ack events, and hand-written conflict, abort and mid-read reset sequences.
module tb_exmem_bram_arbiter;
  localparam int DELAYS = 10;
  localparam int RD_LAT = 1;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1;
  logic [3:0] we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic ack0, ack1;
  logic [31:0] rdata;
  logic [1:0] owner;
  logic bram_en;
  logic [3:0] bram_we;
  logic [ADDR_W-1:0] bram_a;
  logic [31:0] bram_di, bram_do;
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;

  always #5 clk = ~clk;

  exmem_bram_arbiter #(.DELAYS(DELAYS), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .owner(owner),
    .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di), .bram_do(bram_do),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
  );

  // Single-port BRAM, read-first, one cycle read latency
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_a][8*b +: 8] <= bram_di[8*b +: 8];
      bram_do <= mem[bram_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  typedef struct { logic [3:0] we; logic [ADDR_W-1:0] a; logic [31:0] di; int cyc; } issue_t;
  typedef struct { logic [1:0] oh; logic [31:0] rd; int cyc; } ack_t;
  issue_t issue_q[$];
  ack_t   ack_q[$];

  typedef struct { int port; logic [3:0] we; logic [ADDR_W-1:0] addr; logic [31:0] wdata; logic [31:0] rd; int lat; } vec_t;
  vec_t vecs[11];

  // Scoreboard: every BRAM issue and every ack must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en) begin
        if (issue_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_bram_en: got en=1 a=0x%h at cycle %0d, expected no access", bram_a, cyc);
        end else begin
          issue_t it;
          it = issue_q.pop_front();
          check("issue_cycle", 32'(cyc), 32'(it.cyc));
          check("bram_we", {28'h0, bram_we}, {28'h0, it.we});
          check("bram_a", {20'h0, bram_a}, {20'h0, it.a});
          check("bram_di", bram_di, it.di);
        end
      end
      if (ack0 || ack1) begin
        if (ack_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_ack: got ack=%b%b at cycle %0d, expected none", ack1, ack0, cyc);
        end else begin
          ack_t at;
          at = ack_q.pop_front();
          check("ack_port", {30'h0, ack1, ack0}, {30'h0, at.oh});
          check("ack_cycle", 32'(cyc), 32'(at.cyc));
          check("owner_at_ack", {30'h0, owner}, {30'h0, at.oh});
          check("ack_rdata", rdata, at.rd);
        end
      end
    end
  end

  task automatic expect_txn(input int p, input logic [3:0] w, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic [31:0] rd, input int k0, input int lat);
    issue_q.push_back('{w, a, (w != 4'h0) ? d : 32'h0, k0 + DELAYS + 1});
    ack_q.push_back('{(p == 0) ? 2'b01 : 2'b10, rd, k0 + lat});
  endtask

  task automatic start(input int p, input logic [3:0] w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
  endtask

  // Wait (bounded) for the port's ack; garble its attributes once it owns the BRAM
  task automatic wait_ack(input int p);
    bit got = 1'b0;
    bit scr = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!scr && owner == ((p == 0) ? 2'b01 : 2'b10)) begin
        scr = 1'b1;
        if (p == 0) begin we0 = ~we0; addr0 = ~addr0; wdata0 = ~wdata0; end
        else        begin we1 = ~we1; addr1 = ~addr1; wdata1 = ~wdata1; end
      end
      if ((p == 0) ? ack0 : ack1) got = 1'b1;
    end
    check($sformatf("ack%0d_seen", p), {31'h0, got}, 32'h1);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  int k;
  logic [15:0] exp_g0, exp_g1, exp_cf;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 4'h0; we1 = 4'h0;
    addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
    vecs[0]  = '{0, 4'hF, 12'h005, 32'hDEADBEEF, 32'h00000000, 12};
    vecs[1]  = '{1, 4'h0, 12'h005, 32'h00000000, 32'hDEADBEEF, 13};
    vecs[2]  = '{1, 4'h3, 12'h005, 32'h12345678, 32'hDEADBEEF, 12};
    vecs[3]  = '{0, 4'h0, 12'h005, 32'h00000000, 32'hDEAD5678, 13};
    vecs[4]  = '{0, 4'hF, 12'hFFF, 32'hA5A5A5A5, 32'hDEAD5678, 12};
    vecs[5]  = '{1, 4'h0, 12'hFFF, 32'h00000000, 32'hA5A5A5A5, 13};
    vecs[6]  = '{0, 4'hF, 12'h000, 32'hCAFEF00D, 32'hA5A5A5A5, 12};
    vecs[7]  = '{1, 4'h8, 12'h000, 32'h11223344, 32'hA5A5A5A5, 12};
    vecs[8]  = '{0, 4'h0, 12'h000, 32'h00000000, 32'h11FEF00D, 13};
    vecs[9]  = '{1, 4'h4, 12'h005, 32'h99887766, 32'h11FEF00D, 12};
    vecs[10] = '{1, 4'h0, 12'h005, 32'h00000000, 32'hDE885678, 13};

    repeat (3) @(negedge clk);
    check("rst_ack", {30'h0, ack1, ack0}, 32'h0);
    check("rst_owner", {30'h0, owner}, 32'h0);
    check("rst_bram_ctl", {27'h0, bram_en, bram_we}, 32'h0);
    check("rst_bram_a", {20'h0, bram_a}, 32'h0);
    check("rst_bram_di", bram_di, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_cnt", {grant_cnt0, grant_cnt1} | {16'h0, conflict_cnt}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      k = cyc;
      expect_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd, k, vecs[i].lat);
      start(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_ack(vecs[i].port);
    end

    // Fresh reset, then a simultaneous pair: port 0 first, port 1 in the IDLE after ack0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    k = cyc;
    expect_txn(0, 4'hF, 12'h010, 32'h01010101, 32'h0, k, 12);
    expect_txn(1, 4'hF, 12'h011, 32'h02020202, 32'h0, k + 13, 12);
    fork
      begin start(0, 4'hF, 12'h010, 32'h01010101); wait_ack(0); end
      begin start(1, 4'hF, 12'h011, 32'h02020202); wait_ack(1); end
    join
    @(negedge clk); k = cyc;
    expect_txn(0, 4'h0, 12'h010, 32'h0, 32'h01010101, k, 13);
    start(0, 4'h0, 12'h010, 32'h0); wait_ack(0);
    @(negedge clk); k = cyc;
    expect_txn(1, 4'h0, 12'h011, 32'h0, 32'h02020202, k, 13);
    start(1, 4'h0, 12'h011, 32'h0); wait_ack(1);
    @(negedge clk); k = cyc;
    expect_txn(0, 4'hF, 12'h012, 32'h0BADF00D, 32'h02020202, k, 12);
    start(0, 4'hF, 12'h012, 32'h0BADF00D); wait_ack(0);
    @(negedge clk);
`ifdef EXMEM_BRAM_ARB_PERF_EN
    exp_g0 = 16'd3; exp_g1 = 16'd2; exp_cf = 16'd1;
`else
    exp_g0 = 16'd0; exp_g1 = 16'd0; exp_cf = 16'd0;
`endif
    check("grant_cnt0", {16'h0, grant_cnt0}, {16'h0, exp_g0});
    check("grant_cnt1", {16'h0, grant_cnt1}, {16'h0, exp_g1});
    check("conflict_cnt", {16'h0, conflict_cnt}, {16'h0, exp_cf});

    // Port 0 served last, so the next tie goes to port 1
    k = cyc;
    expect_txn(1, 4'hF, 12'h014, 32'h04040404, 32'h02020202, k, 12);
    expect_txn(0, 4'hF, 12'h013, 32'h03030303, 32'h02020202, k + 13, 12);
    fork
      begin start(0, 4'hF, 12'h013, 32'h03030303); wait_ack(0); end
      begin start(1, 4'hF, 12'h014, 32'h04040404); wait_ack(1); end
    join

    // Abort: port 0 drops req at DLY count 4; pending port 1 wins the following IDLE cycle
    @(negedge clk); k = cyc;
    start(0, 4'hF, 12'h020, 32'h77777777);
    repeat (3) @(negedge clk);
    check("owner_dly", {30'h0, owner}, 32'h1);
    start(1, 4'hF, 12'h021, 32'h55AA55AA);
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    expect_txn(1, 4'hF, 12'h021, 32'h55AA55AA, 32'h02020202, k + 6, 12);
    wait_ack(1);

    // Reset during RDWAIT clears everything at once and suppresses the ack
    @(negedge clk); k = cyc;
    issue_q.push_back('{4'h0, 12'h010, 32'h0, k + DELAYS + 1});
    start(0, 4'h0, 12'h010, 32'h0);
    repeat (12) @(negedge clk);
    check("owner_rdwait", {30'h0, owner}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_owner_ack", {28'h0, owner, ack1, ack0}, 32'h0);
    check("midrst_bram_ctl", {27'h0, bram_en, bram_we}, 32'h0);
    check("midrst_bram_a_di", {20'h0, bram_a} | bram_di, 32'h0);
    req0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rdata_after_rst", rdata, 32'h0);
    @(negedge clk); k = cyc;
    expect_txn(1, 4'h0, 12'h011, 32'h0, 32'h02020202, k, 13);
    start(1, 4'h0, 12'h011, 32'h0); wait_ack(1);

    repeat (3) @(negedge clk);
    check("issue_q_drained", 32'(issue_q.size()), 32'h0);
    check("ack_q_drained", 32'(ack_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
